serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// =============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial two's-complement subtractor (a - b - bin), LSB first,
//            with a start/busy/done handshake and held, registered results.
// Revision : 1.0 - initial release
// =============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             br_d;
  logic             d_bit;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             x;
  logic             y;

  // One full-subtractor cell operating on the current LSBs.
  always_comb begin
    x     = a_sr_q[0];
    y     = b_sr_q[0];
    d_bit = x ^ y ^ br_q;
    br_d  = (~x & y) | (~(x ^ y) & br_q);
    res_d = {d_bit, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            br_q    <= bin;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          br_q   <= br_d;
          res_q  <= res_d;
          cnt_q  <= cnt_q + 1'b1;
          // Outputs are only ever written here, so partial results never show.
          if (cnt_q == LAST) begin
            diff    <= res_d;
            bout    <= br_d;
            ovf     <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
            zero    <= (res_d == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// =============================================================================
// Module   : tb_serial_subtractor
// Brief    : Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// Revision : 1.0 - initial release
// =============================================================================
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic        start8 = 1'b0;
  logic        bin8   = 1'b0;
  logic [7:0]  a8     = '0;
  logic [7:0]  b8     = '0;
  logic        busy8, done8, bout8, ovf8, zero8;
  logic [7:0]  diff8;

  logic        start16 = 1'b0;
  logic        bin16   = 1'b0;
  logic [15:0] a16     = '0;
  logic [15:0] b16     = '0;
  logic        busy16, done16, bout16, ovf16, zero16;
  logic [15:0] diff16;

  exp_t sb8[$];
  exp_t sb16[$];
  int   ndone8  = 0;
  int   ndone16 = 0;
  logic [10:0] last8  = '0;
  logic [18:0] last16 = '0;
  exp_t m8_e;
  exp_t m16_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16), .zero(zero16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain wide arithmetic, masked to w bits.
  function automatic exp_t model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                 input logic tbin);
    longint unsigned mask, ua, ub, t;
    exp_t e;
    mask   = (64'd1 << w) - 64'd1;
    ua     = {32'd0, ta} & mask;
    ub     = {32'd0, tb} & mask;
    t      = (ua - ub - {63'd0, tbin}) & mask;
    e.diff = t[31:0];
    e.bout = (ua < (ub + {63'd0, tbin}));
    e.ovf  = (ua[w-1] != ub[w-1]) && (t[w-1] != ua[w-1]);
    e.zero = (t == 64'd0);
    e.acc  = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      last8 = '0;
    end else if (done8 === 1'b1) begin
      ndone8++;
      chk("sb8_has_entry", 32'(sb8.size() != 0), 32'd1);
      if (sb8.size() != 0) begin
        m8_e = sb8.pop_front();
        chk("diff8", 32'(diff8), m8_e.diff);
        chk("bout8", 32'(bout8), 32'(m8_e.bout));
        chk("ovf8",  32'(ovf8),  32'(m8_e.ovf));
        chk("zero8", 32'(zero8), 32'(m8_e.zero));
        chk("latency8", 32'(cyc - m8_e.acc), 32'd8);
        chk("busy8_at_done", 32'(busy8), 32'd0);
      end
      last8 = {diff8, bout8, ovf8, zero8};
    end else begin
      chk("hold8", 32'({diff8, bout8, ovf8, zero8}), 32'(last8));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last16 = '0;
    end else if (done16 === 1'b1) begin
      ndone16++;
      chk("sb16_has_entry", 32'(sb16.size() != 0), 32'd1);
      if (sb16.size() != 0) begin
        m16_e = sb16.pop_front();
        chk("diff16", 32'(diff16), m16_e.diff);
        chk("bout16", 32'(bout16), 32'(m16_e.bout));
        chk("ovf16",  32'(ovf16),  32'(m16_e.ovf));
        chk("zero16", 32'(zero16), 32'(m16_e.zero));
        chk("latency16", 32'(cyc - m16_e.acc), 32'd16);
        chk("busy16_at_done", 32'(busy16), 32'd0);
      end
      last16 = {diff16, bout16, ovf16, zero16};
    end else begin
      chk("hold16", 32'({diff16, bout16, ovf16, zero16}), 32'(last16));
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        output int acc);
    int g = 0;
    while (busy8 === 1'b1 && g < 64) begin
      @(negedge clk);
      g++;
    end
    chk("issue8_not_busy", 32'(busy8), 32'd0);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(negedge clk);
    acc = cyc;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    exp_t e;
    int   acc;
    issue8(ta, tb, tbin, acc);
    e.diff = 32'(ed); e.bout = eb; e.ovf = eo; e.zero = ez; e.acc = acc;
    sb8.push_back(e);
  endtask

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
    exp_t e;
    int   g = 0;
    while (busy16 === 1'b1 && g < 64) begin
      @(negedge clk);
      g++;
    end
    chk("issue16_not_busy", 32'(busy16), 32'd0);
    e = model(16, 32'(ta), 32'(tb), tbin);
    a16 = ta; b16 = tb; bin16 = tbin; start16 = 1'b1;
    @(negedge clk);
    e.acc = cyc;
    sb16.push_back(e);
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
  endtask

  initial begin
    int   acc;
    int   c0;
    int   g;
    int   n0;
    exp_t e;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] ra16;
    logic [15:0] rb16;
    logic        rbi;

    repeat (2) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_res8",  32'({diff8, bout8, ovf8, zero8}), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    chk("rst_res16", 32'({done16, diff16, bout16, ovf16, zero16}), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // First op: also watch busy stay high for exactly WIDTH cycles.
    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("busy8_during_op", 32'(busy8), 32'd1);
      @(negedge clk);
    end
    chk("busy8_after_op", 32'(busy8), 32'd0);
    chk("done8_after_op", 32'(done8), 32'd1);

    op8(8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    op8(8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    op8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
    op8(8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

    // A start pulse mid-operation must be ignored.
    op8(8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;

    // Start held high: back-to-back ops every WIDTH+1 cycles.
    g = 0;
    while (busy8 === 1'b1 && g < 64) begin
      @(negedge clk);
      g++;
    end
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.diff = 32'h7F; e.bout = 1'b0; e.ovf = 1'b1; e.zero = 1'b0; e.acc = c0 + 9 * k;
      sb8.push_back(e);
    end
    while (cyc < c0 + 18) @(negedge clk);
    start8 = 1'b0;

    // Reset four cycles into an operation: outputs clear, no done follows.
    g = 0;
    while (busy8 === 1'b1 && g < 64) begin
      @(negedge clk);
      g++;
    end
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy8", 32'(busy8), 32'd0);
    chk("abort_done8", 32'(done8), 32'd0);
    chk("abort_res8", 32'({diff8, bout8, ovf8, zero8}), 32'd0);
    n0 = ndone8;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", 32'(ndone8), 32'(n0));
    op8(8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom);
      rb  = (i % 10 == 0) ? ra : 8'($urandom);
      rbi = (i % 10 == 0) ? 1'b0 : 1'($urandom);
      e   = model(8, 32'(ra), 32'(rb), rbi);
      op8(ra, rb, rbi, e.diff[7:0], e.bout, e.ovf, e.zero);
    end

    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom);
      rb16 = (i % 10 == 0) ? ra16 : 16'($urandom);
      rbi  = (i % 10 == 0) ? 1'b0 : 1'($urandom);
      op16(ra16, rb16, rbi);
    end

    g = 0;
    while ((sb8.size() != 0 || sb16.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("sb8_drained", 32'(sb8.size()), 32'd0);
    chk("sb16_drained", 32'(sb16.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
